// File: rtl/ehl_gpio_irq_ctrl_if.sv
// ehl_gpio_irq_ctrl_if: pin/config inputs, pending flags and vector/ack handshake of the GPIO irq controller.
interface ehl_gpio_irq_ctrl_if #(parameter int WIDTH = 32, parameter int IDW = 5);
   logic [WIDTH-1:0] pin_in;
   logic [WIDTH-1:0] ien;
   logic [WIDTH-1:0] itype;
   logic [WIDTH-1:0] ipol;
   logic [WIDTH-1:0] iboth;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] pend;
   logic             irq;
   logic             vec_valid;
   logic [IDW-1:0]   vec_id;
   logic             vec_ack;
   modport master (output pin_in, ien, itype, ipol, iboth, clr, vec_ack,
                   input  pend, irq, vec_valid, vec_id);
   modport slave  (input  pin_in, ien, itype, ipol, iboth, clr, vec_ack,
                   output pend, irq, vec_valid, vec_id);
endinterface

// File: rtl/ehl_gpio_irq_ctrl.sv
// ehl_gpio_irq_ctrl: per-pin edge/level pending flags, combined irq and a round-robin vector/ack scheduler.
module ehl_gpio_irq_ctrl #(
   parameter int WIDTH = 32,
   parameter int IDW   = 5
) (
   input logic              clk,
   input logic              reset_n,
   ehl_gpio_irq_ctrl_if.slave bus
);
   typedef enum logic {IDLE, PRESENT} state_t;
   state_t           r_state;
   logic             r_armed;
   logic             r_valid;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_pend;
   logic [IDW-1:0]   r_vec_id;
   logic [IDW-1:0]   r_last;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_evt;
   logic [WIDTH-1:0] w_ack_clr;
   logic [WIDTH-1:0] w_pend_nxt;
   logic [IDW-1:0]   w_sel;
   logic [IDW-1:0]   w_sel_hi;
   logic             w_hit;
   assign w_rise = bus.pin_in & ~r_prev;
   assign w_fall = ~bus.pin_in & r_prev;
   assign w_edge = (bus.iboth & (w_rise | w_fall)) |
                   (~bus.iboth & ((bus.ipol & w_rise) | (~bus.ipol & w_fall)));
   // armed stays low for the first cycle after reset so a pin already high cannot look like an edge
   assign w_evt = {WIDTH{r_armed}} & bus.ien &
                  ((bus.itype & w_edge) | (~bus.itype & ~(bus.pin_in ^ bus.ipol)));
   assign w_ack_clr  = (r_state == PRESENT && bus.vec_ack) ? (WIDTH'(1) << r_vec_id) : '0;
   assign w_pend_nxt = bus.ien & (w_evt | (r_pend & ~bus.clr & ~w_ack_clr));
   // lowest pending index above last grant wins, else lowest pending index overall (wrap)
   always_comb begin
      w_sel    = '0;
      w_sel_hi = '0;
      w_hit    = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (r_pend[i]) begin
            w_sel = IDW'(i);
            if (i > int'(r_last)) begin
               w_sel_hi = IDW'(i);
               w_hit    = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_armed  <= 1'b0;
         r_valid  <= 1'b0;
         r_prev   <= '0;
         r_pend   <= '0;
         r_vec_id <= '0;
         r_last   <= IDW'(WIDTH - 1);
      end else begin
         r_armed <= 1'b1;
         r_prev  <= bus.pin_in;
         r_pend  <= w_pend_nxt;
         if (r_state == IDLE) begin
            if (|r_pend) begin
               r_vec_id <= w_hit ? w_sel_hi : w_sel;
               r_valid  <= 1'b1;
               r_state  <= PRESENT;
            end
         end else if (bus.vec_ack) begin
            r_last  <= r_vec_id;
            r_valid <= 1'b0;
            r_state <= IDLE;
         end else if (!r_pend[r_vec_id]) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
         end
      end
   end
   assign bus.pend      = r_pend;
   assign bus.irq       = |r_pend;
   assign bus.vec_valid = r_valid;
   assign bus.vec_id    = r_vec_id;
endmodule

// File: tb/tb_ehl_gpio_irq_ctrl.sv
// tb_ehl_gpio_irq_ctrl: directed table plus hand sequences for the GPIO interrupt controller.
module tb_ehl_gpio_irq_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;
   ehl_gpio_irq_ctrl_if #(.WIDTH(32), .IDW(5)) bus ();
   ehl_gpio_irq_ctrl #(.WIDTH(32), .IDW(5)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [31:0] pin;
      logic        ack;
      logic [31:0] pend;
      logic        valid;
      logic [4:0]  id;
   } vec_t;
   vec_t tbl[15];
   localparam logic [31:0] M = 32'h4000_0084;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask
   task automatic zero_inputs();
      bus.pin_in = '0; bus.ien = '0; bus.itype = '0; bus.ipol = '0;
      bus.iboth = '0; bus.clr = '0; bus.vec_ack = 1'b0;
   endtask
   task automatic do_reset();
      zero_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask
   initial begin
      tbl[0]  = '{M, 1'b0, M, 1'b0, 5'd0};
      tbl[1]  = '{M, 1'b0, M, 1'b1, 5'd2};
      tbl[2]  = '{M, 1'b1, 32'h4000_0080, 1'b0, 5'd2};
      tbl[3]  = '{M, 1'b0, 32'h4000_0080, 1'b1, 5'd7};
      tbl[4]  = '{M, 1'b1, 32'h4000_0000, 1'b0, 5'd7};
      tbl[5]  = '{M, 1'b0, 32'h4000_0000, 1'b1, 5'd30};
      tbl[6]  = '{M, 1'b1, 32'h0, 1'b0, 5'd30};
      tbl[7]  = '{32'h0, 1'b0, 32'h0, 1'b0, 5'd30};
      tbl[8]  = '{M, 1'b0, M, 1'b0, 5'd30};
      tbl[9]  = '{M, 1'b1, M, 1'b1, 5'd2};
      tbl[10] = '{M, 1'b1, 32'h4000_0080, 1'b0, 5'd2};
      tbl[11] = '{M, 1'b0, 32'h4000_0080, 1'b1, 5'd7};
      tbl[12] = '{M, 1'b1, 32'h4000_0000, 1'b0, 5'd7};
      tbl[13] = '{M, 1'b0, 32'h4000_0000, 1'b1, 5'd30};
      tbl[14] = '{M, 1'b1, 32'h0, 1'b0, 5'd30};
      // pin 3 high through reset, rising-edge type
      zero_inputs();
      bus.pin_in = 32'h8; bus.ien = 32'h8; bus.itype = 32'h8; bus.ipol = 32'h8;
      tick();
      tick();
      chk("rst_pend", bus.pend, 32'h0);
      chk("rst_irq", 32'(bus.irq), 32'h0);
      chk("rst_valid", 32'(bus.vec_valid), 32'h0);
      chk("rst_id", 32'(bus.vec_id), 32'h0);
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("no_spurious_pend", bus.pend, 32'h0);
      end
      bus.pin_in = 32'h0;
      tick();
      bus.pin_in = 32'h8;
      tick();
      chk("p3_pend", bus.pend, 32'h8);
      chk("p3_irq", 32'(bus.irq), 32'h1);
      chk("p3_valid_lag", 32'(bus.vec_valid), 32'h0);
      tick();
      chk("p3_valid", 32'(bus.vec_valid), 32'h1);
      chk("p3_id", 32'(bus.vec_id), 32'd3);
      bus.vec_ack = 1'b1;
      tick();
      bus.vec_ack = 1'b0;
      chk("p3_ack_pend", bus.pend, 32'h0);
      chk("p3_ack_valid", 32'(bus.vec_valid), 32'h0);
      // round robin over pins 2, 7, 30
      do_reset();
      bus.ien = M; bus.itype = M; bus.ipol = M;
      for (int r = 0; r < 15; r++) begin
         bus.pin_in  = tbl[r].pin;
         bus.vec_ack = tbl[r].ack;
         tick();
         chk($sformatf("rr%0d_pend", r), bus.pend, tbl[r].pend);
         chk($sformatf("rr%0d_irq", r), 32'(bus.irq), 32'(|tbl[r].pend));
         chk($sformatf("rr%0d_valid", r), 32'(bus.vec_valid), 32'(tbl[r].valid));
         chk($sformatf("rr%0d_id", r), 32'(bus.vec_id), 32'(tbl[r].id));
      end
      bus.vec_ack = 1'b0;
      // level-high pin 5
      do_reset();
      bus.ien = 32'h20; bus.ipol = 32'h20; bus.pin_in = 32'h20;
      tick();
      chk("lvl_pend", bus.pend, 32'h20);
      tick();
      chk("lvl_valid", 32'(bus.vec_valid), 32'h1);
      chk("lvl_id", 32'(bus.vec_id), 32'd5);
      bus.vec_ack = 1'b1;
      tick();
      bus.vec_ack = 1'b0;
      chk("lvl_reset_pend", bus.pend, 32'h20);
      chk("lvl_gap", 32'(bus.vec_valid), 32'h0);
      tick();
      chk("lvl_repres_valid", 32'(bus.vec_valid), 32'h1);
      chk("lvl_repres_id", 32'(bus.vec_id), 32'd5);
      bus.pin_in = 32'h0;
      tick();
      chk("lvl_hold", bus.pend, 32'h20);
      bus.clr = 32'h20;
      tick();
      bus.clr = 32'h0;
      chk("lvl_clr_pend", bus.pend, 32'h0);
      chk("lvl_clr_irq", 32'(bus.irq), 32'h0);
      tick();
      chk("lvl_withdraw", 32'(bus.vec_valid), 32'h0);
      // edge on pin 9 in the same cycle as clr
      do_reset();
      bus.ien = 32'h200; bus.itype = 32'h200; bus.ipol = 32'h200;
      tick();
      bus.pin_in = 32'h200; bus.clr = 32'h200;
      tick();
      chk("set_beats_clr", bus.pend, 32'h200);
      tick();
      chk("clr_alone", bus.pend, 32'h0);
      bus.clr = 32'h0;
      // pin 4 withdrawn by ien, then pin 6
      do_reset();
      bus.ien = 32'h10; bus.itype = 32'h50; bus.ipol = 32'h50;
      bus.pin_in = 32'h10;
      tick();
      chk("p4_pend", bus.pend, 32'h10);
      tick();
      chk("p4_valid", 32'(bus.vec_valid), 32'h1);
      chk("p4_id", 32'(bus.vec_id), 32'd4);
      bus.ien = 32'h0;
      tick();
      chk("p4_ien_pend", bus.pend, 32'h0);
      chk("p4_still_valid", 32'(bus.vec_valid), 32'h1);
      tick();
      chk("p4_withdrawn", 32'(bus.vec_valid), 32'h0);
      tick();
      chk("p4_no_vector", 32'(bus.vec_valid), 32'h0);
      bus.ien = 32'h40; bus.pin_in = 32'h50;
      tick();
      chk("p6_pend", bus.pend, 32'h40);
      tick();
      chk("p6_valid", 32'(bus.vec_valid), 32'h1);
      chk("p6_id", 32'(bus.vec_id), 32'd6);
      // both-edges pin 1, then reset mid-handshake
      do_reset();
      bus.ien = 32'h2; bus.itype = 32'h2; bus.iboth = 32'h2;
      bus.pin_in = 32'h2;
      tick();
      chk("both_rise", bus.pend, 32'h2);
      bus.clr = 32'h2;
      tick();
      chk("both_clr1", bus.pend, 32'h0);
      bus.clr = 32'h0; bus.pin_in = 32'h0;
      tick();
      chk("both_fall", bus.pend, 32'h2);
      bus.clr = 32'h2;
      tick();
      chk("both_clr2", bus.pend, 32'h0);
      bus.clr = 32'h0; bus.pin_in = 32'h2;
      tick();
      tick();
      chk("mid_valid", 32'(bus.vec_valid), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_valid", 32'(bus.vec_valid), 32'h0);
      chk("async_pend", bus.pend, 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      chk("rearm_no_edge", bus.pend, 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
